// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares one single-port, synchronous-read data memory
// between the CPU load/store port and the debug/loader port.
// Round-robin arbitration in ARB state; LOCK state gives the debug port
// exclusive ownership. Read data returns one cycle after a granted read.
// Optional build macro: ARB_STATS_EN adds a saturating 16-bit conflict_cnt.
`timescale 1ns/1ps

module dmem_port_arbiter #(
    parameter int DBITS  = 32,
    parameter int AWIDTH = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [AWIDTH-1:0] cpu_addr,
    input  logic [DBITS-1:0]  cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DBITS-1:0]  cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [AWIDTH-1:0] dbg_addr,
    input  logic [DBITS-1:0]  dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DBITS-1:0]  dbg_rdata,
    input  logic              dbg_lock,
    output logic              locked,
    output logic              mem_en,
    output logic              mem_we,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DBITS-1:0]  mem_wdata,
    input  logic [DBITS-1:0]  mem_rdata
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]       conflict_cnt
`endif
);

    typedef enum logic {ST_ARB = 1'b0, ST_LOCK = 1'b1} state_t;

    // Requester identities used by rr_last; index 0 = CPU, 1 = DBG.
    localparam logic RR_CPU = 1'b0;
    localparam logic RR_DBG = 1'b1;

    state_t state_reg, state_next;
    logic   rr_last_reg;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_reg <= ST_ARB;
        else       state_reg <= state_next;
    end

    // Next-state logic: enter LOCK only when the CPU is not being served
    // this cycle, so an in-flight CPU grant is never cut off.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_ARB:  if (dbg_lock && !cpu_gnt) state_next = ST_LOCK;
            ST_LOCK: if (!dbg_lock)            state_next = ST_ARB;
            default: state_next = ST_ARB;
        endcase
    end

    // Output logic: grants and lock indication.
    always_comb begin
        cpu_gnt = 1'b0;
        dbg_gnt = 1'b0;
        locked  = 1'b0;
        case (state_reg)
            ST_ARB: begin
                if (cpu_req && dbg_req) begin
                    cpu_gnt = (rr_last_reg == RR_DBG);
                    dbg_gnt = (rr_last_reg == RR_CPU);
                end else begin
                    cpu_gnt = cpu_req;
                    dbg_gnt = dbg_req;
                end
            end
            ST_LOCK: begin
                locked  = 1'b1;
                dbg_gnt = dbg_req;
            end
            default: ;
        endcase
    end

    // Round-robin history; frozen while locked so unlocking resumes fairly.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_last_reg <= RR_DBG;
        end else if (state_reg == ST_ARB) begin
            if (cpu_gnt)      rr_last_reg <= RR_CPU;
            else if (dbg_gnt) rr_last_reg <= RR_DBG;
        end
    end

    // Memory-side mux; everything is driven to 0 when idle.
    always_comb begin
        mem_en    = cpu_gnt | dbg_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (dbg_gnt) begin
            mem_we    = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
        end
    end

    // Per-port read return path, identical for both requesters.
    logic [1:0]       port_gnt;
    logic [1:0]       port_we;
    logic [1:0]       rvalid_reg;
    logic [DBITS-1:0] rdata_hold_reg [2];
    logic [DBITS-1:0] port_rdata     [2];

    assign port_gnt = {dbg_gnt, cpu_gnt};
    assign port_we  = {dbg_we,  cpu_we};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd_return
            // rvalid pulses the cycle after a granted read; the held copy
            // keeps rdata stable once that pulse has passed.
            always_ff @(posedge clk) begin
                if (reset) begin
                    rvalid_reg[gi]     <= 1'b0;
                    rdata_hold_reg[gi] <= '0;
                end else begin
                    rvalid_reg[gi] <= port_gnt[gi] && !port_we[gi];
                    if (rvalid_reg[gi]) rdata_hold_reg[gi] <= mem_rdata;
                end
            end
            assign port_rdata[gi] = rvalid_reg[gi] ? mem_rdata : rdata_hold_reg[gi];
        end
    endgenerate

    assign cpu_rvalid = rvalid_reg[0];
    assign dbg_rvalid = rvalid_reg[1];
    assign cpu_rdata  = port_rdata[0];
    assign dbg_rdata  = port_rdata[1];

`ifdef ARB_STATS_EN
    logic [15:0] conflict_cnt_reg;

    // Saturating count of contention cycles (both requesting, or CPU
    // held off by the debug lock).
    always_ff @(posedge clk) begin
        if (reset) begin
            conflict_cnt_reg <= '0;
        end else if (((cpu_req && dbg_req) || (state_reg == ST_LOCK && cpu_req))
                     && conflict_cnt_reg != 16'hFFFF) begin
            conflict_cnt_reg <= conflict_cnt_reg + 16'd1;
        end
    end

    assign conflict_cnt = conflict_cnt_reg;
`endif

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the processor's single-port, synchronous-read data memory between two requesters: the CPU load/store port and a debug/loader port. The debug port is driven by the board-level SW/KEY front end and lets a user inspect or patch memory.
- Provides round-robin arbitration, a debug lock mode for exclusive access, per-requester grant/stall, and read-data return with 1-cycle latency.
- Sits between the CPU datapath and the data memory, inside the top-level processor wrapper.

Parameters:
- DBITS, 32, data word width
- AWIDTH, 12, word-address width of data memory

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU access request
- cpu_we  in  1  CPU write enable (0 = read)
- cpu_addr  in  AWIDTH  CPU word address
- cpu_wdata  in  DBITS  CPU write data
- cpu_gnt  out  1  CPU request accepted this cycle; CPU stalls while cpu_req && !cpu_gnt
- cpu_rvalid  out  1  CPU read data valid
- cpu_rdata  out  DBITS  CPU read data
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_gnt, dbg_rvalid, dbg_rdata: same as the cpu_* ports, for the debug port
- dbg_lock  in  1  debug port requests exclusive ownership
- locked  out  1  arbiter is in LOCK state
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  AWIDTH  memory address
- mem_wdata  out  DBITS  memory write data
- mem_rdata  in  DBITS  memory read data, valid the cycle after a read strobe

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (reset).
- Reset values:
  - state = ARB; rr_last = DBG, so the CPU wins the first conflict.
  - cpu_rvalid, dbg_rvalid, locked = 0.
  - Read-data outputs = 0.
- Grants are combinational from the requests, state and rr_last. At most one grant is asserted per cycle.
- State ARB:
  - Only one requester has req=1: that requester is granted.
  - Both have req=1: the requester other than rr_last is granted.
  - On every grant, rr_last <= the granted requester.
- Transition ARB -> LOCK:
  - Occurs on the clock edge where dbg_lock=1 and no CPU grant is issued that cycle.
  - A debug access may be granted in that same cycle.
- State LOCK:
  - locked=1; cpu_gnt is forced to 0.
  - dbg_gnt = dbg_req.
  - rr_last is not updated.
- Transition LOCK -> ARB: on the clock edge where dbg_lock=0. The CPU is eligible in the following cycle.
- Memory side:
  - mem_en = cpu_gnt | dbg_gnt.
  - mem_we, mem_addr and mem_wdata are muxed from the granted port.
  - All memory outputs are 0 when nothing is granted.
- Read return:
  - A granted read (we=0) sets that port's rvalid for exactly one cycle, on the next cycle.
  - That port's rdata = mem_rdata in that cycle.
  - rdata holds its last value when rvalid=0.
- Writes: a granted write completes at the edge of its grant cycle. It produces no rvalid.
- Back-to-back requests: a port may be granted every cycle when uncontested. Under continuous contention, grants alternate CPU/DBG.
- Reset mid-operation: any pending rvalid is dropped, LOCK is exited, and rr_last returns to DBG.
- A request held with req=1 and no grant must keep its addr/we/wdata stable. The arbiter does not latch them.

Optional Feature:
- Macro ARB_STATS_EN.
- When defined, adds output conflict_cnt [15:0]:
  - Increments each cycle both requests are asserted, plus each LOCK cycle with cpu_req=1.
  - Saturates at 16'hFFFF.
  - Resets to 0.
- When not defined, the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then CPU-only read of addr 12'h010 with memory word 32'hDEADBEEF:
  - cpu_gnt=1 in cycle 0.
  - mem_en=1, mem_addr=12'h010.
  - cpu_rvalid=1 and cpu_rdata=32'hDEADBEEF in cycle 1; dbg_rvalid stays 0.
- Both ports request continuously for 4 cycles after reset:
  - Grants are CPU, DBG, CPU, DBG.
  - mem_addr alternates accordingly.
  - conflict_cnt=4 when ARB_STATS_EN is defined.
- dbg_lock=1 with dbg writes 32'h00000005 to 12'h020 while cpu_req=1 for 5 cycles:
  - cpu_gnt=0 throughout; locked=1.
  - Memory at 12'h020 reads back 32'h5.
  - After dbg_lock drops, cpu_gnt=1 within 2 cycles.
- CPU write 32'h12345678 to 12'h004, then CPU read of 12'h004 on the next cycle:
  - Two consecutive grants.
  - cpu_rvalid pulses once, with rdata=32'h12345678.
- Reset asserted the cycle after a granted dbg read:
  - dbg_rvalid stays 0; locked=0.
  - The next conflict is granted to the CPU.
- ARB_STATS_EN defined, both ports requesting for 70000 cycles: conflict_cnt saturates at 16'hFFFF.
